// File: rtl/cmt_pkg.sv
// cmt_pkg: shared register map, CMCSR bit positions and clock-select encodings
package cmt_pkg;
  typedef enum logic {IDLE, ACK} state_t;
  typedef enum logic [1:0] {CKS_8, CKS_32, CKS_128, CKS_512} cks_t;
  localparam logic [2:0] A_CMSTR  = 3'd0;
  localparam logic [2:0] A_CMCSR0 = 3'd1;
  localparam logic [2:0] A_CMCNT0 = 3'd2;
  localparam logic [2:0] A_CMCOR0 = 3'd3;
  localparam logic [2:0] A_CMCSR1 = 3'd4;
  localparam logic [2:0] A_CMCNT1 = 3'd5;
  localparam logic [2:0] A_CMCOR1 = 3'd6;
  localparam int CSR_CMF  = 7;
  localparam int CSR_CMIE = 6;
  localparam int CSR_CKS  = 0;
endpackage

// File: rtl/cmt_ch_reg.sv
// cmt_ch_reg: per-channel CMCSR/CMCOR registers, flag clear handshake, preload and irq
module cmt_ch_reg
  import cmt_pkg::*;
#(
  parameter logic [15:0] RST_COR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic        cnt_we,
  input  logic        cor_we,
  input  logic        csr_rd,
  input  logic [15:0] wdata,
  input  logic        cmf_i,
  output logic [1:0]  cks,
  output logic [15:0] cor,
  output logic        set_cnt,
  output logic [15:0] wdata_cnt,
  output logic        irq,
  output logic [15:0] csr
);
  logic cmf, cmie, arm, clr;
  cks_t cks_q;
  // A flag may only be cleared after software has seen it set
  assign clr = csr_we & ~wdata[CSR_CMF] & arm;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmf       <= 1'b0;
      cmie      <= 1'b0;
      arm       <= 1'b0;
      cks_q     <= CKS_8;
      cor       <= RST_COR;
      set_cnt   <= 1'b0;
      wdata_cnt <= '0;
    end else begin
      cmf     <= cmf_i | (cmf & ~clr);
      arm     <= ~csr_we & (arm | (csr_rd & cmf));
      set_cnt <= cnt_we;
      if (csr_we) begin
        cmie  <= wdata[CSR_CMIE];
        cks_q <= cks_t'(wdata[CSR_CKS +: 2]);
      end
      if (cor_we) cor <= wdata;
      if (cnt_we) wdata_cnt <= wdata;
    end
  assign cks = cks_q;
  assign irq = cmf & cmie;
  assign csr = {8'h00, cmf, cmie, 4'h0, cks_q};
endmodule

// File: rtl/cmt_reg.sv
// cmt_reg: two-channel compare-match timer register block with one-cycle-ack bus
module cmt_reg
  import cmt_pkg::*;
#(
  parameter logic [15:0] CORE_RST_CMCOR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        ack_o,
  output logic        str0_o,
  output logic        str1_o,
  output logic [1:0]  cks0_o,
  output logic [1:0]  cks1_o,
  output logic [15:0] const0_o,
  output logic [15:0] const1_o,
  output logic        set_cnt0_o,
  output logic        set_cnt1_o,
  output logic [15:0] wdata_cnt0_o,
  output logic [15:0] wdata_cnt1_o,
  input  logic        cmf0_i,
  input  logic        cmf1_i,
  input  logic [15:0] cnt0_i,
  input  logic [15:0] cnt1_i,
  output logic        irq0_o,
  output logic        irq1_o
);
  state_t state, state_d;
  logic accept, wr, rd, unused_addr;
  logic [2:0] idx;
  logic [1:0] str;
  logic [15:0] csr0, csr1, rmux;
  assign unused_addr = addr_i[0];
  assign idx = addr_i[3:1];
  assign accept = (state == IDLE) & req_i;
  assign wr = accept & we_i;
  assign rd = accept & ~we_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_comb state_d = accept ? ACK : IDLE;
  always_comb ack_o = (state == ACK);
  always_comb begin
    rmux = '0;
    case (idx)
      A_CMSTR:  rmux = {14'h0, str};
      A_CMCSR0: rmux = csr0;
      A_CMCNT0: rmux = cnt0_i;
      A_CMCOR0: rmux = const0_o;
      A_CMCSR1: rmux = csr1;
      A_CMCNT1: rmux = cnt1_i;
      A_CMCOR1: rmux = const1_o;
      default:  rmux = '0;
    endcase
  end
  // rdata is only non-zero during the ACK cycle of a read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdata_o <= '0;
      str     <= '0;
    end else begin
      rdata_o <= rd ? rmux : '0;
      str     <= (wr && idx == A_CMSTR) ? wdata_i[1:0] : str;
    end
  assign str0_o = str[0];
  assign str1_o = str[1];
  cmt_ch_reg #(.RST_COR(CORE_RST_CMCOR)) u_ch0 (
    .clk(clk), .rst(rst),
    .csr_we(wr && idx == A_CMCSR0), .cnt_we(wr && idx == A_CMCNT0),
    .cor_we(wr && idx == A_CMCOR0), .csr_rd(rd && idx == A_CMCSR0),
    .wdata(wdata_i), .cmf_i(cmf0_i), .cks(cks0_o), .cor(const0_o),
    .set_cnt(set_cnt0_o), .wdata_cnt(wdata_cnt0_o), .irq(irq0_o), .csr(csr0)
  );
  cmt_ch_reg #(.RST_COR(CORE_RST_CMCOR)) u_ch1 (
    .clk(clk), .rst(rst),
    .csr_we(wr && idx == A_CMCSR1), .cnt_we(wr && idx == A_CMCNT1),
    .cor_we(wr && idx == A_CMCOR1), .csr_rd(rd && idx == A_CMCSR1),
    .wdata(wdata_i), .cmf_i(cmf1_i), .cks(cks1_o), .cor(const1_o),
    .set_cnt(set_cnt1_o), .wdata_cnt(wdata_cnt1_o), .irq(irq1_o), .csr(csr1)
  );
endmodule

// File: doc/cmt_reg.md
CMT_REG -- requirements
Module: cmt_reg

Interface
REQ-001 SHALL have parameter CORE_RST_CMCOR, default 16'hFFFF, reset value of both CMCOR registers.
REQ-002 SHALL have port clk  input  1  single clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_i  input  1  bus transfer request, held until ack_o.
REQ-005 SHALL have port we_i  input  1  1=write, 0=read; qualified by req_i.
REQ-006 SHALL have port addr_i  input  4  byte address; addr_i[3:1] selects the register.
REQ-007 SHALL have port wdata_i  input  16  write data.
REQ-008 SHALL have port rdata_o  output  16  read data, valid while ack_o=1, else 0.
REQ-009 SHALL have port ack_o  output  1  one-cycle transfer acknowledge.
REQ-010 SHALL have ports str0_o/str1_o  output  1  timer start bits.
REQ-011 SHALL have ports cks0_o/cks1_o  output  2  clock select (00 :8, 01 :32, 10 :128, 11 :512).
REQ-012 SHALL have ports const0_o/const1_o  output  16  compare constants (CMCOR).
REQ-013 SHALL have ports set_cnt0_o/set_cnt1_o  output  1 and wdata_cnt0_o/wdata_cnt1_o  output  16  counter preload pulse and value.
REQ-014 SHALL have ports cmf0_i/cmf1_i  input  1  one-cycle match pulses from the timer.
REQ-015 SHALL have ports cnt0_i/cnt1_i  input  16  live counter values.
REQ-016 SHALL have ports irq0_o/irq1_o  output  1  level interrupts.

Function
REQ-017 SHALL decode addr_i[3:1]: 0 CMSTR (bit0 str0, bit1 str1), 1 CMCSR0, 2 CMCNT0, 3 CMCOR0, 4 CMCSR1, 5 CMCNT1, 6 CMCOR1, 7 reserved (reads 0, writes ignored).
REQ-018 SHALL lay out CMCSRn as bit7 CMF, bit6 CMIE, bits1:0 CKS; other bits read 0.
REQ-019 SHALL use two states IDLE/ACK: IDLE with req_i=1 -> ACK (transfer performed on that edge); ACK -> IDLE unconditionally; ack_o=1 only in ACK.
REQ-020 SHALL give exactly one-cycle latency from request sample to ack_o and ignore req_i while in ACK.
REQ-021 SHALL register rdata_o on the accepting edge; CMCNTn reads return cnt_i as sampled on that edge.
REQ-022 SHALL, on a write to CMCNTn, assert set_cntn_o for exactly one cycle (the ACK cycle) with wdata_cntn_o = wdata_i held stable through that cycle.
REQ-023 SHALL set CMFn on any cycle with cmfn_i=1, regardless of CMIE or str.
REQ-024 SHALL clear CMFn only on a CMCSRn write with wdata_i[7]=0 after CMFn was read as 1 (per-channel arm bit set by that read); writing 1 to bit7 SHALL have no effect on CMF.
REQ-025 SHALL clear the arm bit on any CMCSRn write and whenever CMFn is cleared.
REQ-026 SHALL give cmfn_i priority: a clearing write coinciding with cmfn_i=1 leaves CMFn=1 and the arm bit cleared.
REQ-027 SHALL drive irqn_o = CMFn & CMIEn, combinational from registered bits.
REQ-028 SHALL drive strn_o, cksn_o, constn_o directly from register bits, taking effect the cycle after the accepting edge.

Reset
REQ-029 SHALL, while rst=1, asynchronously force: state IDLE, ack_o=0, rdata_o=0, str=0, CKS=00, CMIE=0, CMF=0, arm bits 0, set_cnt=0, wdata_cnt=0, CMCOR=CORE_RST_CMCOR, irq=0.
REQ-030 SHALL abandon an in-flight transfer on reset; first ack after release needs a fresh request.

Structure
REQ-031 SHALL place register address indices, CMCSR bit positions and CKS encodings in shared package cmt_pkg.
REQ-032 SHALL instantiate one sub-module cmt_ch_reg per channel (CMCSR, CMCOR, arm, preload, irq), twice; CMSTR and bus FSM stay in top.

Verification
REQ-033 SHALL cover: reset -> const0_o=16'hFFFF, cks0_o=0, str0_o=0, irq0_o=0, ack_o=0.
REQ-034 SHALL cover: write CMCOR0=16'h0010 at addr 6 -> ack_o 1 cycle later, const0_o=16'h0010 next cycle, read returns 16'h0010.
REQ-035 SHALL cover: write CMCSR0=16'h0040, pulse cmf0_i -> irq0_o=1; read CMCSR0 -> 16'h00C0; write 16'h0040 -> CMF0=0, irq0_o=0.
REQ-036 SHALL cover: write 16'h0040 to CMCSR0 without prior read while CMF0=1 -> CMF0 stays 1.
REQ-037 SHALL cover: clearing write coinciding with cmf0_i=1 -> CMF0=1, irq0_o stays 1.
REQ-038 SHALL cover: write CMCNT1=16'h1234 -> set_cnt1_o=1 for one cycle with wdata_cnt1_o=16'h1234; CMSTR=16'h0003 -> str0_o=str1_o=1.
